// File: rtl/fir_tap_sequencer_pkg.sv
// Shared width derivations and sequencer state encoding for the FIR tap sequencer.
package fir_tap_sequencer_pkg;

   function automatic int calc_aw(input int taps);
      return $clog2(taps);
   endfunction

   function automatic int calc_pw(input int n, input int cw);
      return n + cw;
   endfunction

   // One guard bit per doubling of TAPS keeps a full-scale sum from wrapping.
   function automatic int calc_acc_w(input int n, input int cw, input int taps);
      return n + cw + $clog2(taps);
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample, result, coefficient and delay-line signals of the FIR tap sequencer.
interface fir_tap_sequencer_if import fir_tap_sequencer_pkg::*; #(
   parameter int N    = 8,
   parameter int TAPS = 16,
   parameter int CW   = 8
);
   localparam int AW    = calc_aw(TAPS);
   localparam int ACC_W = calc_acc_w(N, CW, TAPS);

   logic                    in_valid;
   logic signed [N-1:0]     in_data;
   logic                    in_ready;
   logic                    coef_we;
   logic [AW-1:0]           coef_addr;
   logic signed [CW-1:0]    coef_data;
   logic                    asr_enable;
   logic signed [N-1:0]     asr_q;
   logic [AW-1:0]           asr_addr;
   logic signed [N-1:0]     asr_dataout;
   logic                    out_valid;
   logic signed [ACC_W-1:0] out_data;
   logic                    out_ready;

   modport master (
      output in_valid, in_data, coef_we, coef_addr, coef_data, asr_dataout, out_ready,
      input  in_ready, asr_enable, asr_q, asr_addr, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, coef_we, coef_addr, coef_data, asr_dataout, out_ready,
      output in_ready, asr_enable, asr_q, asr_addr, out_valid, out_data
   );

endinterface

// File: rtl/fir_coef_regfile.sv
// Coefficient storage: one synchronous write port, one combinational read port.
module fir_coef_regfile #(
   parameter int TAPS = 16,
   parameter int CW   = 8,
   parameter int AW   = $clog2(TAPS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic signed [CW-1:0] wdata,
   input  logic [AW-1:0]        raddr,
   output logic signed [CW-1:0] rdata
);

   logic signed [CW-1:0] mem [TAPS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read sees the pre-write value when the same entry is written this cycle.
   assign rdata = mem[raddr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequences one delay-line sweep per accepted sample and accumulates the FIR result.
//
// state | meaning
// IDLE  | ready for a new sample; accept shifts the delay line
// SWEEP | TAPS cycles reading tap k and capturing tap*coef products
// DRAIN | adds the final product, loads the result register
// HOLD  | result offered until out_ready
module fir_tap_sequencer import fir_tap_sequencer_pkg::*; #(
   parameter int N    = 8,
   parameter int TAPS = 16,
   parameter int CW   = 8
) (
   input  logic                clk,
   input  logic                reset,
   fir_tap_sequencer_if.slave  bus
);

   localparam int AW    = calc_aw(TAPS);
   localparam int PW    = calc_pw(N, CW);
   localparam int ACC_W = calc_acc_w(N, CW, TAPS);

   state_t                  state;
   logic [AW-1:0]           addr;
   logic signed [PW-1:0]    p;
   logic                    p_valid;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_sum;
   logic                    out_valid_q;
   logic signed [ACC_W-1:0] out_data_q;
   logic signed [CW-1:0]    coef_rd;
   logic signed [PW-1:0]    samp_ext;
   logic signed [PW-1:0]    coef_ext;
   logic signed [PW-1:0]    prod;
   logic                    accept;

   fir_coef_regfile #(
      .TAPS (TAPS),
      .CW   (CW),
      .AW   (AW)
   ) u_coef (
      .clk   (clk),
      .reset (reset),
      .we    (bus.coef_we),
      .waddr (bus.coef_addr),
      .wdata (bus.coef_data),
      .raddr (addr),
      .rdata (coef_rd)
   );

   // Reset gating keeps the strobes quiet during the reset cycle itself.
   assign bus.in_ready   = (state == IDLE) && !reset;
   assign accept         = bus.in_valid && bus.in_ready;
   assign bus.asr_enable = accept;
   assign bus.asr_q      = bus.in_data;
   assign bus.asr_addr   = (state == SWEEP && !reset) ? addr : '0;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;

   // Both operands sign-extended to PW so the truncated product is exact.
   assign samp_ext = {{CW{bus.asr_dataout[N-1]}}, bus.asr_dataout};
   assign coef_ext = {{N{coef_rd[CW-1]}}, coef_rd};
   assign prod     = samp_ext * coef_ext;
   assign acc_sum  = acc + {{AW{p[PW-1]}}, p};

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         addr        <= '0;
         p           <= '0;
         p_valid     <= 1'b0;
         acc         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         p_valid <= (state == SWEEP);
         if (state == SWEEP) p <= prod;
         if (p_valid) acc <= acc_sum;
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= SWEEP;
                  addr  <= '0;
                  acc   <= '0;
               end
            end
            SWEEP: begin
               // addr wraps back to 0 on the last tap since TAPS is a power of two.
               addr <= addr + AW'(1);
               if (addr == AW'(TAPS - 1)) state <= DRAIN;
            end
            DRAIN: begin
               state       <= HOLD;
               out_valid_q <= 1'b1;
               out_data_q  <= acc_sum;
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed and randomized checks of the FIR tap sequencer against a sum-of-products model.
module tb_fir_tap_sequencer;
   localparam int N     = 8;
   localparam int TAPS  = 16;
   localparam int CW    = 8;
   localparam int AW    = $clog2(TAPS);
   localparam int ACC_W = N + CW + AW;

   logic clk;
   logic reset;
   int   n_assert = 0;
   int   n_fail   = 0;

   int hist   [TAPS];
   int coef_m [TAPS];

   logic signed [N-1:0] dl [TAPS];

   fir_tap_sequencer_if #(.N(N), .TAPS(TAPS), .CW(CW)) bus ();

   fir_tap_sequencer #(.N(N), .TAPS(TAPS), .CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Delay line external to the sequencer; cleared by the shared reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) dl[i] <= '0;
      end else if (bus.asr_enable) begin
         dl[0] <= bus.asr_q;
         for (int i = 1; i < TAPS; i++) dl[i] <= dl[i-1];
      end
   end
   assign bus.asr_dataout = dl[bus.asr_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Result = sum over taps of coef*sample; a mid-sweep write to tap wa in
   // cycle wc only affects taps read after that edge (k >= wc).
   function automatic logic signed [ACC_W-1:0] model_result(input int wc, input int wa, input int wd);
      longint sum = 0;
      int c;
      for (int k = 0; k < TAPS; k++) begin
         c = (wc > 0 && k == wa && k >= wc) ? wd : coef_m[k];
         sum += longint'(c) * longint'(hist[k]);
      end
      return ACC_W'(sum);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < TAPS; k++) begin
         hist[k]   = 0;
         coef_m[k] = 0;
      end
   endtask

   task automatic write_coef(input int a, input int d);
      @(negedge clk);
      bus.coef_we   = 1'b1;
      bus.coef_addr = AW'(a);
      bus.coef_data = CW'(d);
      @(posedge clk);
      #1;
      bus.coef_we = 1'b0;
      coef_m[a]   = d;
   endtask

   task automatic send_sample(input logic signed [N-1:0] x, input int bp,
                              input int wc, input int wa, input int wd);
      logic signed [ACC_W-1:0] exp_r;
      int c;
      bit got;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      #1;
      chk("in_ready_idle", bus.in_ready, 1);
      chk("asr_enable_accept", bus.asr_enable, 1);
      chk("asr_q", bus.asr_q, x);
      for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'(x);
      exp_r = model_result(wc, wa, wd);
      c   = 0;
      got = 0;
      while (!got && c < 40) begin
         @(negedge clk);
         c++;
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_data   = N'($urandom);
         bus.coef_we   = (c == wc);
         bus.coef_addr = AW'(wa);
         bus.coef_data = CW'(wd);
         #1;
         if (bus.out_valid) begin
            got = 1;
         end else begin
            chk("asr_addr", bus.asr_addr, (c >= 1 && c <= TAPS) ? c - 1 : 0);
            chk("asr_enable_busy", bus.asr_enable, 0);
            chk("in_ready_busy", bus.in_ready, 0);
         end
      end
      bus.coef_we = 1'b0;
      if (wc > 0) coef_m[wa] = wd;
      chk("latency", c, TAPS + 2);
      chk("out_data", bus.out_data, exp_r);
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         #1;
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_out_data", bus.out_data, exp_r);
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_asr_enable", bus.asr_enable, 0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      #1;
      chk("handoff_no_accept", bus.asr_enable, 0);
      chk("handoff_out_valid", bus.out_valid, 1);
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      #1;
      chk("post_handoff_out_valid", bus.out_valid, 0);
      chk("post_handoff_in_ready", bus.in_ready, 1);
   endtask

   initial begin
      logic signed [N-1:0] xs;
      logic [7:0]          r;

      reset         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'sd33;
      bus.coef_we   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      bus.out_ready = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_asr_enable", bus.asr_enable, 0);
      chk("rst_asr_addr", bus.asr_addr, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      @(negedge clk);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("rst_in_ready", bus.in_ready, 1);

      // Impulse response with backpressure on the first result
      for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
      send_sample(8'sd1, 5, 0, 0, 0);
      for (int i = 0; i < TAPS; i++) send_sample(8'sd0, 0, 0, 0, 0);

      // DC input
      for (int k = 0; k < TAPS; k++) write_coef(k, 1);
      for (int i = 0; i < TAPS; i++) send_sample(8'sd4, 0, 0, 0, 0);

      // Full-scale negative extremes
      for (int k = 0; k < TAPS; k++) write_coef(k, -128);
      for (int i = 0; i < TAPS; i++) send_sample(-8'sd128, 0, 0, 0, 0);

      // Write to coef[3] in the very cycle tap 3 is read, then the follow-up sample
      write_coef(3, 2);
      send_sample(8'sd5, 0, 4, 3, 7);
      send_sample(-8'sd3, 1, 0, 0, 0);

      // Randomized coefficients, samples, backpressure and mid-sweep writes
      for (int k = 0; k < TAPS; k++) begin
         r = 8'($urandom);
         write_coef(k, int'($signed(r)));
      end
      for (int i = 0; i < 12; i++) begin
         xs = N'($urandom);
         r  = 8'($urandom);
         if (i % 3 == 2)
            send_sample(xs, $urandom_range(0, 3), $urandom_range(1, TAPS),
                        $urandom_range(0, TAPS - 1), int'($signed(r)));
         else
            send_sample(xs, $urandom_range(0, 3), 0, 0, 0);
      end

      // Reset in the middle of a sweep discards the result and clears coefficients
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'sd55;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         if (c == 5) reset = 1'b1;
      end
      #1;
      chk("midrst_asr_addr", bus.asr_addr, 0);
      chk("midrst_asr_enable", bus.asr_enable, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_in_ready", bus.in_ready, 1);
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_out_data", bus.out_data, 0);
      model_clear();
      send_sample(8'sd77, 0, 0, 0, 0);
      send_sample(-8'sd100, 2, 0, 0, 0);
      write_coef(0, 3);
      send_sample(8'sd9, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
